// File: rtl/ts4231_config_scheduler_pkg.sv
// ts4231_pkg: shared definitions for the TS4231 configuration scheduler and
// its neighbours (configurators, tracker arbiter).
//   sched_state_t   - scheduler FSM states
//   CLK_HZ          - system clock frequency (96 MHz)
//   CFG_TICK_CYCLES - configurator bit-sampling period in clk cycles
//   CFG_WORD        - TS4231 configuration word
//   cfg_word_bit()  - MSB-first bit of CFG_WORD for a serializer
package ts4231_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SELECT,
    CLEAR,
    PULSE,
    WAIT,
    NEXT
  } sched_state_t;

  localparam int unsigned CLK_HZ          = 96000000;
  localparam int unsigned CFG_TICK_CYCLES = 96;
  localparam logic [15:0] CFG_WORD        = 16'h7256;

  // Bit 'pos' of the configuration word, counting from the MSB (pos 0).
  function automatic logic cfg_word_bit(input logic [3:0] pos);
    return CFG_WORD[4'd15 - pos];
  endfunction

endpackage

// File: rtl/ts4231_config_scheduler_rr_pick.sv
// rr_pick: combinational round-robin picker.
//   mask  - request bits
//   ptr   - search start position (highest priority)
//   grant - one-hot of the lowest set mask bit at or above ptr, wrapping
//   idx   - binary index of grant
//   valid - mask had at least one bit set
module rr_pick #(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0]         mask,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         grant,
  output logic [$clog2(N)-1:0] idx,
  output logic                 valid
);

  localparam int unsigned IW = $clog2(N);
  localparam int unsigned SW = IW + 1;
  localparam logic [SW-1:0] NV = SW'(N);

  logic [SW-1:0] sum;
  logic [IW-1:0] cand;

  // Scan positions ptr, ptr+1, ... (mod N); ptr < N and offset < N, so a
  // single conditional subtraction performs the wrap.
  always_comb begin
    grant = '0;
    idx   = '0;
    valid = 1'b0;
    sum   = '0;
    cand  = '0;
    for (int unsigned k = 0; k < N; k++) begin
      sum = {1'b0, ptr} + SW'(k);
      if (sum >= NV) begin
        sum = sum - NV;
      end
      cand = sum[IW-1:0];
      if (!valid && mask[cand]) begin
        valid       = 1'b1;
        idx         = cand;
        grant[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ts4231_config_scheduler.sv
// ts4231_config_scheduler: configures NUM_SENSORS TS4231 front-ends one at a
// time. The active configurator is cleared for 2 cycles, given a
// PULSE_CYCLES-long reconfigure pulse, then watched for its configured flag
// with a timeout and up to MAX_RETRY further attempts.
//
// Ports:
//   clk, rst          - clock, synchronous active-high reset
//   start             - pulse: mark all sensors pending
//   req               - per-sensor re-configuration request pulses
//   cfg_clear         - clear to each configurator (active sensor only)
//   cfg_reconfigure   - reconfigure level to each configurator
//   cfg_configured    - sticky configured flag from each configurator
//   configured_mask   - sensors successfully configured
//   failed_mask       - sensors that exhausted their retries
//   busy              - state machine not idle
//   active_idx        - sensor currently (or last) serviced
//   done              - one-cycle pulse when the pending set drains
//   e_activity        - (TS4231_SCHED_WATCHDOG_EN only) envelope activity
//                       strobes feeding the per-sensor loss watchdogs
//
// Optional feature macro: TS4231_SCHED_WATCHDOG_EN adds e_activity and
// LOST_CYCLES; a configured sensor silent for LOST_CYCLES is re-queued.
module ts4231_config_scheduler
  import ts4231_pkg::*;
#(
  parameter int unsigned NUM_SENSORS    = 4,
  parameter int unsigned PULSE_CYCLES   = 2 * CFG_TICK_CYCLES,
  parameter int unsigned TIMEOUT_CYCLES = CLK_HZ / 10,
  parameter int unsigned MAX_RETRY      = 3
`ifdef TS4231_SCHED_WATCHDOG_EN
  ,
  parameter int unsigned LOST_CYCLES    = CLK_HZ / 5
`endif
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic [NUM_SENSORS-1:0]         req,
  output logic [NUM_SENSORS-1:0]         cfg_clear,
  output logic [NUM_SENSORS-1:0]         cfg_reconfigure,
  input  logic [NUM_SENSORS-1:0]         cfg_configured,
`ifdef TS4231_SCHED_WATCHDOG_EN
  input  logic [NUM_SENSORS-1:0]         e_activity,
`endif
  output logic [NUM_SENSORS-1:0]         configured_mask,
  output logic [NUM_SENSORS-1:0]         failed_mask,
  output logic                           busy,
  output logic [$clog2(NUM_SENSORS)-1:0] active_idx,
  output logic                           done
);

  localparam int unsigned IW = $clog2(NUM_SENSORS);
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES);
  localparam int unsigned PW = $clog2(PULSE_CYCLES);
  localparam int unsigned RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [PW-1:0] PULSE_LAST = PW'(PULSE_CYCLES - 1);
  localparam logic [RW-1:0] RETRY_MAX  = RW'(MAX_RETRY);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_SENSORS - 1);

  sched_state_t           state;
  logic [NUM_SENSORS-1:0] pending;
  logic [TW-1:0]          timer;
  logic [PW-1:0]          pulse_cnt;
  logic [RW-1:0]          retry;
  logic [IW-1:0]          rr_ptr;
  logic                   clear_phase;
  logic                   hold_again;
  logic                   came_from_next;

  logic [NUM_SENSORS-1:0] pick_grant;
  logic [IW-1:0]          pick_idx;
  logic                   pick_any;

  logic [NUM_SENSORS-1:0] active_oh;
  logic [NUM_SENSORS-1:0] pending_set;
  logic [NUM_SENSORS-1:0] retire;
  logic                   serving;
  logic                   success;
  logic                   exhausted;
  logic                   keep;

  rr_pick #(
    .N(NUM_SENSORS)
  ) u_pick (
    .mask  (pending),
    .ptr   (rr_ptr),
    .grant (pick_grant),
    .idx   (pick_idx),
    .valid (pick_any)
  );

  always_comb begin
    active_oh             = '0;
    active_oh[active_idx] = 1'b1;
  end

  assign serving   = (state == CLEAR) || (state == PULSE) || (state == WAIT);
  assign success   = (state == WAIT) && cfg_configured[active_idx];
  assign exhausted = (state == WAIT) && !cfg_configured[active_idx] &&
                     (timer == TIMER_LAST) && (retry >= RETRY_MAX);

  // The active sensor's pending bit stays set for the whole service, so a
  // request for it would otherwise be absorbed and then wiped at retire.
  // hold_again remembers such a request; keep suppresses the retire.
  assign keep   = hold_again | req[active_idx] | start;
  assign retire = ((success || exhausted) && !keep) ? active_oh : '0;

`ifdef TS4231_SCHED_WATCHDOG_EN
  localparam int unsigned LW = $clog2(LOST_CYCLES);
  localparam logic [LW-1:0] LOST_LAST = LW'(LOST_CYCLES - 1);

  logic [LW-1:0]          wd_cnt [NUM_SENSORS];
  logic [NUM_SENSORS-1:0] lost;
  logic [NUM_SENSORS-1:0] wd_hold;

  always_comb begin
    wd_hold = '0;
    lost    = '0;
    for (int unsigned i = 0; i < NUM_SENSORS; i++) begin
      wd_hold[i] = e_activity[i] || failed_mask[i] ||
                   (serving && (active_idx == IW'(i)));
      lost[i]    = !wd_hold[i] && (wd_cnt[i] == LOST_LAST) && configured_mask[i];
    end
  end

  // Counters saturate at LOST_LAST for sensors that are not configured, and
  // restart after raising a loss so a still-silent sensor is re-queued again.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_SENSORS; i++) begin
        wd_cnt[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < NUM_SENSORS; i++) begin
        if (wd_hold[i] || lost[i]) begin
          wd_cnt[i] <= '0;
        end else if (wd_cnt[i] != LOST_LAST) begin
          wd_cnt[i] <= wd_cnt[i] + LW'(1);
        end
      end
    end
  end

  assign pending_set = req | {NUM_SENSORS{start}} | lost;
`else
  assign pending_set = req | {NUM_SENSORS{start}};
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      pending         <= '0;
      timer           <= '0;
      pulse_cnt       <= '0;
      retry           <= '0;
      rr_ptr          <= '0;
      clear_phase     <= 1'b0;
      hold_again      <= 1'b0;
      came_from_next  <= 1'b0;
      cfg_clear       <= '0;
      cfg_reconfigure <= '0;
      configured_mask <= '0;
      failed_mask     <= '0;
      busy            <= 1'b0;
      active_idx      <= '0;
      done            <= 1'b0;
    end else begin
      pending        <= (pending | pending_set) & ~retire;
      came_from_next <= (state == NEXT);
      done           <= 1'b0;

      if (serving && (req[active_idx] || start)) begin
        hold_again <= 1'b1;
      end

      unique case (state)
        IDLE: begin
          if (pending != '0) begin
            state <= SELECT;
            busy  <= 1'b1;
          end else if (came_from_next) begin
            done <= 1'b1;
          end
        end

        SELECT: begin
          if (pick_any) begin
            active_idx      <= pick_idx;
            rr_ptr          <= (pick_idx == IDX_LAST) ? '0 : pick_idx + IW'(1);
            configured_mask <= configured_mask & ~pick_grant;
            failed_mask     <= failed_mask & ~pick_grant;
            cfg_clear       <= pick_grant;
            clear_phase     <= 1'b0;
            hold_again      <= req[pick_idx] | start;
            state           <= CLEAR;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end

        CLEAR: begin
          if (clear_phase) begin
            cfg_clear       <= '0;
            cfg_reconfigure <= active_oh;
            pulse_cnt       <= '0;
            state           <= PULSE;
          end else begin
            clear_phase <= 1'b1;
          end
        end

        PULSE: begin
          if (pulse_cnt == PULSE_LAST) begin
            cfg_reconfigure <= '0;
            timer           <= '0;
            state           <= WAIT;
          end else begin
            pulse_cnt <= pulse_cnt + PW'(1);
          end
        end

        WAIT: begin
          if (success) begin
            configured_mask <= configured_mask | active_oh;
            state           <= NEXT;
          end else if (timer == TIMER_LAST) begin
            if (retry < RETRY_MAX) begin
              retry       <= retry + RW'(1);
              cfg_clear   <= active_oh;
              clear_phase <= 1'b0;
              state       <= CLEAR;
            end else begin
              failed_mask <= failed_mask | active_oh;
              state       <= NEXT;
            end
          end else begin
            timer <= timer + TW'(1);
          end
        end

        NEXT: begin
          retry      <= '0;
          hold_again <= 1'b0;
          if (pending != '0) begin
            state <= SELECT;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ts4231_config_scheduler.sv
// Bench for ts4231_config_scheduler: mock configurators answer reconfigure
// pulses after a programmable delay; a monitor logs each attempt (index,
// clear length, pulse length). Expected service order and masks come from a
// round-robin model of the scheduling rules.
`timescale 1ns/1ps
module tb_ts4231_config_scheduler;

  localparam int unsigned N     = 4;
  localparam int unsigned PULSE = 192;
  localparam int unsigned TMO   = 1500;
  localparam int unsigned MAXR  = 3;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [N-1:0] req = '0;
  logic [N-1:0] cfg_clear, cfg_reconfigure, configured_mask, failed_mask;
  logic [N-1:0] cfg_configured = '0;
  logic         busy, done;
  logic [1:0]   active_idx;
`ifdef TS4231_SCHED_WATCHDOG_EN
  logic [N-1:0] e_activity = '1;
`endif

  ts4231_config_scheduler #(
    .NUM_SENSORS   (N),
    .PULSE_CYCLES  (PULSE),
    .TIMEOUT_CYCLES(TMO),
    .MAX_RETRY     (MAXR)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .req            (req),
    .cfg_clear      (cfg_clear),
    .cfg_reconfigure(cfg_reconfigure),
    .cfg_configured (cfg_configured),
`ifdef TS4231_SCHED_WATCHDOG_EN
    .e_activity     (e_activity),
`endif
    .configured_mask(configured_mask),
    .failed_mask    (failed_mask),
    .busy           (busy),
    .active_idx     (active_idx),
    .done           (done)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // ---------------- mock configurators ----------------
  logic [N-1:0] resp_m = '1;
  int unsigned  dly [N];
  int           cnt [N];
  bit           armed [N];
  logic [N-1:0] rec_q = '0;

  always @(negedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (rst || cfg_clear[i]) begin
        cfg_configured[i] = 1'b0;
        armed[i] = 1'b0;
      end else begin
        if (rec_q[i] && !cfg_reconfigure[i]) begin
          armed[i] = 1'b1;
          cnt[i]   = int'(dly[i]);
        end
        if (armed[i]) begin
          if (cnt[i] == 0) begin
            armed[i] = 1'b0;
            cfg_configured[i] = resp_m[i];
          end else begin
            cnt[i]--;
          end
        end
      end
    end
    rec_q = cfg_reconfigure;
  end

  // ---------------- attempt monitor ----------------
  typedef struct {
    int idx;
    int clr_idx;
    int clr_len;
    int pul_len;
  } att_t;

  att_t att_q[$];
  att_t tmp_att;
  int   clr_run = 0, clr_len_s = 0, clr_idx_s = -1, pul_run = 0, pul_idx = -1;
  int   viol = 0;
  int   done_cnt = 0;

  function automatic int oh_idx(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return -1;
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      clr_run = 0;
      pul_run = 0;
    end else begin
      if (done) done_cnt++;
      if ($countones(cfg_clear) > 1 || $countones(cfg_reconfigure) > 1 ||
          (cfg_clear != '0 && cfg_reconfigure != '0))
        viol++;
      if (cfg_reconfigure != '0 && oh_idx(cfg_reconfigure) != int'(active_idx))
        viol++;
      if (cfg_clear != '0) begin
        clr_run++;
        clr_idx_s = oh_idx(cfg_clear);
      end else if (clr_run != 0) begin
        clr_len_s = clr_run;
        clr_run = 0;
      end
      if (cfg_reconfigure != '0) begin
        pul_run++;
        pul_idx = oh_idx(cfg_reconfigure);
      end else if (pul_run != 0) begin
        tmp_att.idx     = pul_idx;
        tmp_att.clr_idx = clr_idx_s;
        tmp_att.clr_len = clr_len_s;
        tmp_att.pul_len = pul_run;
        att_q.push_back(tmp_att);
        pul_run = 0;
      end
    end
  end

  // ---------------- reference model ----------------
  int           mptr = 0;
  logic [N-1:0] m_cfg = '0, m_fail = '0;
  int           exp_q[$];
  int           last_n_att = 0;

  // Sensors are taken in circular order starting at the pointer; each
  // takes one attempt if responsive, otherwise 1 + MAXR attempts and fails.
  task automatic model_batch(input logic [N-1:0] pend);
    int last;
    int j;
    last = -1;
    for (int k = 0; k < N; k++) begin
      j = (mptr + k) % N;
      if (pend[j]) begin
        repeat (resp_m[j] ? 1 : 1 + MAXR) exp_q.push_back(j);
        m_cfg[j]  = resp_m[j];
        m_fail[j] = ~resp_m[j];
        last = j;
      end
    end
    if (last >= 0) mptr = (last + 1) % N;
  endtask

  task automatic check_attempts(input string nm);
    int n;
    last_n_att = att_q.size();
    check({nm, "_attempts"}, att_q.size(), exp_q.size());
    n = (att_q.size() < exp_q.size()) ? att_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s_idx%0d", nm, i), att_q[i].idx, exp_q[i]);
      check($sformatf("%s_clridx%0d", nm, i), att_q[i].clr_idx, exp_q[i]);
      check($sformatf("%s_clrlen%0d", nm, i), att_q[i].clr_len, 2);
      check($sformatf("%s_pullen%0d", nm, i), att_q[i].pul_len, PULSE);
    end
    att_q.delete();
    exp_q.delete();
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic pulse_in(input logic st, input logic [N-1:0] rq);
    @(negedge clk);
    start = st;
    req   = rq;
    @(negedge clk);
    start = 1'b0;
    req   = '0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (done) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_rec(input int i, input logic lvl, input int budget, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (cfg_reconfigure[i] === lvl) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic set_delay(input int unsigned d);
    for (int i = 0; i < N; i++) dly[i] = d;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    start = 1'b0;
    req = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    mptr = 0;
    m_cfg = '0;
    m_fail = '0;
    att_q.delete();
    exp_q.delete();
  endtask

  task automatic run_batch(input logic st, input logic [N-1:0] rq, input string nm);
    bit ok;
    int d0;
    model_batch(st ? '1 : rq);
    d0 = done_cnt;
    pulse_in(st, rq);
    wait_done(exp_q.size() * (TMO + PULSE + 20) + 200, ok);
    check({nm, "_done_seen"}, ok, 1);
    check({nm, "_busy"}, busy, 0);
    check({nm, "_cfg_mask"}, configured_mask, m_cfg);
    check({nm, "_fail_mask"}, failed_mask, m_fail);
    repeat (3) @(negedge clk);
    check({nm, "_done_once"}, done_cnt - d0, 1);
    check_attempts(nm);
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic         st;
    logic [N-1:0] rq;
    logic [N-1:0] resp;
    int unsigned  d;
    logic [N-1:0] exp_cfg;
    logic [N-1:0] exp_fail;
    int           exp_n;
  } vec_t;

  vec_t tbl [4];

  initial begin
    bit ok;
    int d0;

    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    bit ok;
    int d0;

    tbl[0] = '{1'b1, 4'b0000, 4'b1111, 1000, 4'b1111, 4'b0000, 4};
    tbl[1] = '{1'b1, 4'b0000, 4'b1011,  300, 4'b1011, 4'b0100, 7};
    tbl[2] = '{1'b0, 4'b0100, 4'b1111,  300, 4'b1111, 4'b0000, 1};
    tbl[3] = '{1'b0, 4'b0011, 4'b1111,  300, 4'b1111, 4'b0000, 2};
    set_delay(1000);

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_clear", cfg_clear, 0);
    check("rst_reconf", cfg_reconfigure, 0);
    check("rst_cfg", configured_mask, 0);
    check("rst_fail", failed_mask, 0);
    check("rst_busy", busy, 0);
    check("rst_idx", active_idx, 0);
    check("rst_done", done, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Table: basic run, timeout/retry, single req, wrapped req pair
    for (int v = 0; v < 4; v++) begin
      resp_m = tbl[v].resp;
      set_delay(tbl[v].d);
      run_batch(tbl[v].st, tbl[v].rq, $sformatf("tbl%0d", v));
      check($sformatf("tbl%0d_cfg_const", v), configured_mask, tbl[v].exp_cfg);
      check($sformatf("tbl%0d_fail_const", v), failed_mask, tbl[v].exp_fail);
      check($sformatf("tbl%0d_natt_const", v), last_n_att, tbl[v].exp_n);
    end

    // Round-robin fairness: req[0], req[3] while sensor 1 is served -> 3 then 0
    do_reset();
    resp_m = '1;
    set_delay(200);
    d0 = done_cnt;
    pulse_in(1'b0, 4'b0010);
    wait_rec(1, 1'b1, 50, ok);
    check("rr_s1_pulse_seen", ok, 1);
    pulse_in(1'b0, 4'b1001);
    wait_done(4 * (TMO + PULSE + 20), ok);
    check("rr_done_seen", ok, 1);
    exp_q = '{1, 3, 0};
    check("rr_cfg_mask", configured_mask, 4'b1011);
    check("rr_fail_mask", failed_mask, 4'b0000);
    repeat (3) @(negedge clk);
    check("rr_done_once", done_cnt - d0, 1);
    check_attempts("rr");

    // Re-request of the active sensor during WAIT -> served twice, one done
    set_delay(300);
    d0 = done_cnt;
    pulse_in(1'b0, 4'b0010);
    wait_rec(1, 1'b1, 50, ok);
    check("rereq_pulse_hi", ok, 1);
    wait_rec(1, 1'b0, PULSE + 10, ok);
    check("rereq_pulse_lo", ok, 1);
    repeat (50) @(negedge clk);
    check("rereq_in_wait", busy, 1);
    pulse_in(1'b0, 4'b0010);
    wait_done(4 * (TMO + PULSE + 20), ok);
    check("rereq_done_seen", ok, 1);
    exp_q = '{1, 1};
    check("rereq_cfg_mask", configured_mask, 4'b1011);
    repeat (3) @(negedge clk);
    check("rereq_done_once", done_cnt - d0, 1);
    check_attempts("rereq");

    // Reset in the middle of sensor 0's pulse
    do_reset();
    set_delay(200);
    pulse_in(1'b1, 4'b0000);
    wait_rec(0, 1'b1, 50, ok);
    check("rstmid_pulse_seen", ok, 1);
    repeat (50) @(negedge clk);
    d0 = done_cnt;
    rst = 1'b1;
    @(negedge clk);
    check("rstmid_clear", cfg_clear, 0);
    check("rstmid_reconf", cfg_reconfigure, 0);
    check("rstmid_cfg", configured_mask, 0);
    check("rstmid_fail", failed_mask, 0);
    check("rstmid_busy", busy, 0);
    check("rstmid_idx", active_idx, 0);
    check("rstmid_done", done, 0);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    check("rstmid_stays_idle", busy, 0);
    check("rstmid_no_done", done_cnt - d0, 0);
    check("rstmid_no_attempt", att_q.size(), 0);
    mptr = 0;
    m_cfg = '0;
    m_fail = '0;
    att_q.delete();
    run_batch(1'b1, 4'b0000, "restart");

    // Randomised batches against the model
    for (int r = 0; r < 6; r++) begin
      logic         st;
      logic [N-1:0] rq;
      for (int i = 0; i < N; i++) begin
        resp_m[i] = ($urandom_range(0, 7) != 0);
        dly[i]    = $urandom_range(5, 400);
      end
      st = ($urandom_range(0, 3) == 0);
      rq = st ? 4'b0000 : 4'($urandom_range(1, 15));
      run_batch(st, rq, $sformatf("rnd%0d", r));
    end

    check("onehot_drive_violations", viol, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
